ex_mem_port_arbiter: RTL and testbench

- Arbitrates one single-ported, variable-latency memory between two requesters: instruction fetch (I) and the load/store datapath (D).
- D is fed by the EX/MEM register's memrd/memwr, address (ALU result) and write data.
- Sequences each access with a multi-cycle FSM and returns registered data with a one-cycle ready pulse.
- Produces the pipeline stall used to freeze the EX/MEM and earlier registers.

---
 rtl/ex_mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_ex_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch (I) and the
// EX/MEM load/store path (D); sequences each access and produces the pipeline stall.
module ex_mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [1:0]        state_q, state_d;
    logic              own_d_q, own_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;

    logic d_req, grant_d, grant_i, complete;

    assign d_req = d_rd | d_wr;
    // D has priority unless I has been passed over STARVE_MAX times in a row.
    assign grant_d  = d_req & ~(i_req & (starve_q == CNT_MAX));
    assign grant_i  = i_req & ~grant_d;
    assign complete = ((state_q == ISSUE) || (state_q == WAIT)) && mem_ready;

    always_comb begin
        state_d   = state_q;
        own_d_d   = own_d_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = ISSUE;
                    own_d_d = 1'b1;
                    addr_d  = d_addr;
                    wen_d   = d_wr;
                    wdata_d = d_wdata;
                    if (!i_req) begin
                        starve_d = '0;
                    end else if (starve_q != CNT_MAX) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (grant_i) begin
                    state_d  = ISSUE;
                    own_d_d  = 1'b0;
                    addr_d   = i_addr;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    starve_d = '0;
                end
            end
            ISSUE:   state_d = complete ? RESP : WAIT;
            WAIT:    state_d = complete ? RESP : WAIT;
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (own_d_q) begin
                d_ready_d = 1'b1;
                if (!wen_q) d_rdata_d = mem_rdata;
            end else begin
                i_ready_d = 1'b1;
                i_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            own_d_q   <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            starve_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_d_q   <= own_d_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            starve_q  <= starve_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
        end
    end

    assign mem_cen   = (state_q == ISSUE);
    assign mem_wen   = wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign stall     = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_ex_mem_port_arbiter.sv
// Scoreboard bench for ex_mem_port_arbiter: stimulus queues expected memory commands and
// responses; a monitor and a memory responder check and serve them independently.
module tb_ex_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ready, d_rd, d_wr, d_ready;
    logic [29:0] i_addr, d_addr, mem_addr;
    logic [31:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic        mem_cen, mem_wen, mem_ready, stall;

    ex_mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic        wen;
        logic [31:0] wdata;
    } cmd_t;
    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } rsp_t;
    typedef struct {
        logic [31:0] data;
        int          waits;
    } mem_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    mem_t mem_q[$];
    int   tests = 0;
    int   fails = 0;
    logic [31:0] last_d = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Queue one access: the command the memory should see, its response, and the ready.
    task automatic push(input logic is_d, input logic wen, input logic [29:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mdata, input int waits,
                        input bit exp_rsp);
        cmd_t c;
        mem_t m;
        rsp_t r;
        c.addr = addr; c.wen = wen; c.wdata = wdata;
        m.data = mdata; m.waits = waits;
        cmd_q.push_back(c);
        mem_q.push_back(m);
        if (exp_rsp) begin
            if (is_d && !wen) last_d = mdata;
            r.is_d = is_d;
            r.data = is_d ? last_d : mdata;
            rsp_q.push_back(r);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ready(input bit is_d, output int cyc);
        cyc = 1;
        while (1) begin
            step();
            cyc++;
            if (is_d ? d_ready : i_ready) break;
            if (cyc > 60) begin
                check(is_d ? "d_ready timeout" : "i_ready timeout", 0, 1);
                break;
            end
        end
    endtask

    // Memory responder: answers each mem_cen after the queued number of wait cycles.
    initial begin
        mem_t m;
        int   wl;
        bit   pend;
        pend = 0;
        wl = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_cen === 1'b1 && !rst) begin
                if (mem_q.size() != 0) begin
                    m = mem_q.pop_front();
                    mem_rdata = m.data;
                    wl = m.waits;
                    if (wl == 0) mem_ready = 1'b1;
                    else pend = 1;
                end
            end else if (pend) begin
                wl--;
                if (wl == 0) begin
                    mem_ready = 1'b1;
                    pend = 0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a command or a ready pulse.
    initial begin
        cmd_t cur;
        rsp_t r;
        bit   active;
        active = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                active = 0;
            end else begin
                if (mem_cen) begin
                    if (cmd_q.size() == 0) flag("unexpected mem_cen");
                    else begin
                        cur = cmd_q.pop_front();
                        active = 1;
                        check("mem_addr", 64'(mem_addr), 64'(cur.addr));
                        check("mem_wen", 64'(mem_wen), 64'(cur.wen));
                        if (cur.wen) check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    end
                end else if (active) begin
                    check("held mem_addr", 64'(mem_addr), 64'(cur.addr));
                    check("held mem_wen", 64'(mem_wen), 64'(cur.wen));
                    if (cur.wen) check("held mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                end
                if (i_ready || d_ready) active = 0;
                check("single ready", 64'(i_ready & d_ready), 0);
                if (i_ready) begin
                    if (rsp_q.size() == 0) flag("unexpected i_ready");
                    else begin
                        r = rsp_q.pop_front();
                        check("i_ready owner", 64'(r.is_d), 0);
                        check("i_rdata", 64'(i_rdata), 64'(r.data));
                    end
                end
                if (d_ready) begin
                    if (rsp_q.size() == 0) flag("unexpected d_ready");
                    else begin
                        r = rsp_q.pop_front();
                        check("d_ready owner", 64'(r.is_d), 1);
                        check("d_rdata", 64'(d_rdata), 64'(r.data));
                    end
                end
                check("stall", 64'(stall),
                      64'((i_req & ~i_ready) | ((d_rd | d_wr) & ~d_ready)));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        i_req = 0; i_addr = '0;
        d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;

        // Reset then idle
        step();
        step();
        check("rst i_ready", 64'(i_ready), 0);
        check("rst d_ready", 64'(d_ready), 0);
        check("rst i_rdata", 64'(i_rdata), 0);
        check("rst d_rdata", 64'(d_rdata), 0);
        check("rst mem_cen", 64'(mem_cen), 0);
        check("rst mem_wen", 64'(mem_wen), 0);
        check("rst mem_addr", 64'(mem_addr), 0);
        check("rst mem_wdata", 64'(mem_wdata), 0);
        check("rst stall", 64'(stall), 0);
        rst = 1'b0;
        repeat (4) step();

        // Single zero-wait fetch
        push(0, 0, 30'h10, '0, 32'hDEADBEEF, 0, 1);
        i_addr = 30'h10;
        i_req = 1;
        #1;
        check("fetch stall on request", 64'(stall), 1);
        wait_ready(0, lat);
        check("fetch latency", 64'(lat), 3);
        i_req = 0;
        step();

        // Load with one wait, then store with two waits; d_rdata must keep the load value
        push(1, 0, 30'h24, '0, 32'hCAFEF00D, 1, 1);
        d_addr = 30'h24;
        d_rd = 1;
        wait_ready(1, lat);
        check("load latency", 64'(lat), 4);
        d_rd = 0;
        step();
        push(1, 1, 30'h20, 32'h12345678, 32'h55555555, 2, 1);
        d_addr = 30'h20;
        d_wdata = 32'h12345678;
        d_wr = 1;
        wait_ready(1, lat);
        check("store latency", 64'(lat), 5);
        d_wr = 0;
        step();

        // Contention: D first, then I
        push(1, 0, 30'h200, '0, 32'h11112222, 1, 1);
        push(0, 0, 30'h50, '0, 32'h33334444, 0, 1);
        fork
            begin
                int c;
                d_addr = 30'h200;
                d_rd = 1;
                wait_ready(1, c);
                d_rd = 0;
            end
            begin
                int c;
                i_addr = 30'h50;
                i_req = 1;
                wait_ready(0, c);
                check("contention I latency", 64'(c), 7);
                i_req = 0;
            end
        join
        step();

        // Starvation: four D grants, then I forced, then D again (counter cleared)
        for (int k = 0; k < 4; k++) push(1, 0, 30'h100 + 30'(k), '0, 32'hA0000000 + k, k % 2, 1);
        push(0, 0, 30'h40, '0, 32'hB0000000, 0, 1);
        push(1, 0, 30'h104, '0, 32'hA0000004, 0, 1);
        push(0, 0, 30'h44, '0, 32'hB0000001, 1, 1);
        fork
            begin
                int c;
                for (int k = 0; k < 5; k++) begin
                    d_addr = 30'h100 + 30'(k);
                    d_rd = 1;
                    wait_ready(1, c);
                end
                d_rd = 0;
            end
            begin
                int c;
                for (int k = 0; k < 2; k++) begin
                    i_addr = 30'h40 + 30'(4 * k);
                    i_req = 1;
                    wait_ready(0, c);
                end
                i_req = 0;
            end
        join
        step();

        // Reset during WAIT; the late mem_ready must be ignored
        push(1, 0, 30'h30, '0, 32'h77778888, 3, 0);
        d_addr = 30'h30;
        d_rd = 1;
        lat = 0;
        while (!mem_cen && lat < 20) begin
            step();
            lat++;
        end
        check("reset test issue seen", 64'(mem_cen), 1);
        step();
        rst = 1;
        d_rd = 0;
        step();
        step();
        rst = 0;
        last_d = '0;
        repeat (5) step();
        check("post-reset i_rdata", 64'(i_rdata), 0);
        check("post-reset d_rdata", 64'(d_rdata), 0);
        check("post-reset mem_cen", 64'(mem_cen), 0);
        check("post-reset stall", 64'(stall), 0);

        // Normal service resumes after reset
        push(0, 0, 30'h3C, '0, 32'h0BADF00D, 0, 1);
        i_addr = 30'h3C;
        i_req = 1;
        wait_ready(0, lat);
        check("post-reset fetch latency", 64'(lat), 3);
        i_req = 0;
        repeat (3) step();

        check("cmd queue drained", 64'(cmd_q.size()), 0);
        check("rsp queue drained", 64'(rsp_q.size()), 0);
        check("mem queue drained", 64'(mem_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
